// File: rtl/rx_frame_pkg.sv
// Shared constants, error codes and state encoding for the receive-frame controller.
package rx_frame_pkg;

    // Frame layout: src, dst, len header bytes, then payload, then two CRC bytes.
    localparam int         HDR_LEN    = 3;
    localparam int         CRC_LEN    = 2;
    localparam logic [7:0] BCAST_ADDR = 8'hFF;

    // Error classification reported on err_code.
    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_INCOMPLETE = 2'd1;
    localparam logic [1:0] ERR_CRC        = 2'd2;
    localparam logic [1:0] ERR_OVERSIZE   = 2'd3;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RECV = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Byte count as reported in wr_flags, clipped to 0xFF.
    function automatic logic [7:0] sat_byte(input logic [31:0] n);
        return (n > 32'd255) ? 8'hFF : n[7:0];
    endfunction

endpackage

// File: rtl/rx_frame_match.sv
// Address comparator: enabled-slot hits with lowest-index priority, plus broadcast.
module rx_frame_match #(
    parameter int NUM_FILTERS = 2,
    parameter int IDX_W       = 2
) (
    input  logic [8*NUM_FILTERS-1:0] filters,
    input  logic [NUM_FILTERS-1:0]   filter_en,
    input  logic [7:0]               addr,
    output logic                     hit_src,
    output logic                     hit_dst,
    output logic [IDX_W-1:0]         idx
);
    import rx_frame_pkg::*;

    logic [NUM_FILTERS-1:0] hit_vec;

    generate
        for (genvar gi = 0; gi < NUM_FILTERS; gi++) begin : g_cmp
            assign hit_vec[gi] = filter_en[gi] && (filters[8*gi +: 8] == addr);
        end
    endgenerate

    // Priority encode: scanning downward leaves the lowest matching slot; no hit keeps all-ones.
    always_comb begin
        hit_src = |hit_vec;
        hit_dst = (|hit_vec) || (addr == BCAST_ADDR);
        idx     = '1;
        for (int k = NUM_FILTERS - 1; k >= 0; k--) begin
            if (hit_vec[k]) begin
                idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/rx_frame_ctl.sv
// Receive-frame controller: parses src/dst/len/data/crc, writes bytes to the RX RAM,
// swaps RAM pages per frame, classifies errors and keeps good/error counters.
module rx_frame_ctl #(
    parameter int ADDR_W      = 8,
    parameter int NUM_FILTERS = 2,
    parameter int MAX_DATA    = 253,
    parameter int CNT_W       = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [8*NUM_FILTERS-1:0]      filters,
    input  logic [NUM_FILTERS-1:0]        filter_en,
    input  logic                          promisc,
    input  logic                          user_crc,
    input  logic                          not_drop,
    input  logic                          abort,
    input  logic                          cnt_clr,
    output logic                          error,
    output logic [1:0]                    err_code,
    output logic [$clog2(NUM_FILTERS):0]  match_idx,
    input  logic                          ser_bus_idle,
    input  logic [7:0]                    ser_data,
    input  logic [15:0]                   ser_crc_data,
    input  logic                          ser_data_clk,
    output logic                          ser_force_wait_idle,
    output logic [7:0]                    wr_byte,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic                          wr_clk,
    output logic [7:0]                    wr_flags,
    output logic                          switch,
    output logic [CNT_W-1:0]              cnt_ok,
    output logic [CNT_W-1:0]              cnt_err
);
    import rx_frame_pkg::*;

    localparam int              IDX_W    = $clog2(NUM_FILTERS) + 1;
    localparam logic [7:0]      MAX_LEN  = 8'(MAX_DATA);
    // Index of the last byte relative to data_len (header + crc - 1).
    localparam logic [ADDR_W:0] TAIL_OFS = (ADDR_W+1)'(HDR_LEN + CRC_LEN - 1);

    state_t            state;
    logic [ADDR_W:0]   byte_cnt;
    logic [7:0]        data_len;
    logic              drop;

    logic              m_hit_src;
    logic              m_hit_dst;
    logic [IDX_W-1:0]  m_idx;

    logic rx_strobe, rx_idle, last_byte, crc_pass;
    logic ovs_evt, good_evt, crc_evt, inc_evt, ok_evt, err_evt;

    rx_frame_match #(
        .NUM_FILTERS (NUM_FILTERS),
        .IDX_W       (IDX_W)
    ) u_match (
        .filters   (filters),
        .filter_en (filter_en),
        .addr      (ser_data),
        .hit_src   (m_hit_src),
        .hit_dst   (m_hit_dst),
        .idx       (m_idx)
    );

    // Frame-level event decode for the current cycle.
    always_comb begin
        rx_strobe = (state == ST_RECV) && ser_data_clk && !ser_bus_idle;
        rx_idle   = (state == ST_RECV) && ser_bus_idle && (byte_cnt != '0);
        last_byte = rx_strobe && (byte_cnt == ((ADDR_W+1)'(data_len) + TAIL_OFS));
        crc_pass  = (ser_crc_data == 16'h0000) || user_crc;
        ovs_evt   = rx_strobe && (byte_cnt == (ADDR_W+1)'(2)) && (ser_data > MAX_LEN) && !drop;
        good_evt  = last_byte && !drop && crc_pass;
        crc_evt   = last_byte && !drop && !crc_pass;
        inc_evt   = rx_idle && (((byte_cnt >= (ADDR_W+1)'(2)) && !drop) || promisc);
        ok_evt    = good_evt && !abort;
        err_evt   = (ovs_evt || crc_evt || inc_evt) && !abort;
    end

    // Main FSM with registered strobes; abort overrides everything in its cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= ST_INIT;
            byte_cnt            <= '0;
            data_len            <= '0;
            drop                <= 1'b0;
            error               <= 1'b0;
            err_code            <= ERR_NONE;
            match_idx           <= '0;
            ser_force_wait_idle <= 1'b0;
            wr_byte             <= '0;
            wr_addr             <= '0;
            wr_clk              <= 1'b0;
            wr_flags            <= '0;
            switch              <= 1'b0;
        end else begin
            error               <= 1'b0;
            switch              <= 1'b0;
            wr_clk              <= 1'b0;
            ser_force_wait_idle <= 1'b0;
            if (abort) begin
                state <= ST_INIT;
            end else begin
                case (state)
                    ST_INIT: begin
                        ser_force_wait_idle <= !ser_bus_idle;
                        byte_cnt            <= '0;
                        data_len            <= '0;
                        drop                <= 1'b0;
                        match_idx           <= '0;
                        state               <= ST_RECV;
                    end
                    ST_RECV: begin
                        if (rx_idle) begin
                            state <= ST_INIT;
                            if (inc_evt) begin
                                error    <= 1'b1;
                                err_code <= ERR_INCOMPLETE;
                                if (not_drop) begin
                                    wr_flags <= sat_byte(32'(byte_cnt));
                                    switch   <= 1'b1;
                                end
                            end
                        end else if (rx_strobe) begin
                            wr_byte <= ser_data;
                            wr_addr <= byte_cnt[ADDR_W-1:0];
                            wr_clk  <= !byte_cnt[ADDR_W] && !drop;
                            if (byte_cnt != '1) begin
                                byte_cnt <= byte_cnt + 1'b1;
                            end
                            // Self-echo: our own address appearing as source.
                            if ((byte_cnt == '0) && m_hit_src && !promisc) begin
                                drop <= 1'b1;
                            end
                            if (byte_cnt == (ADDR_W+1)'(1)) begin
                                if (m_hit_dst || promisc) begin
                                    match_idx <= m_idx;
                                end else begin
                                    drop <= 1'b1;
                                end
                            end
                            if (byte_cnt == (ADDR_W+1)'(2)) begin
                                data_len <= ser_data;
                            end
                            if (ovs_evt) begin
                                error    <= 1'b1;
                                err_code <= ERR_OVERSIZE;
                                if (not_drop) begin
                                    wr_flags <= 8'd3;
                                    switch   <= 1'b1;
                                end
                                state <= ST_WAIT;
                            end else if (last_byte) begin
                                state <= ST_INIT;
                                if (good_evt) begin
                                    wr_flags <= 8'd0;
                                    switch   <= 1'b1;
                                end else if (crc_evt) begin
                                    error    <= 1'b1;
                                    err_code <= ERR_CRC;
                                    if (not_drop) begin
                                        wr_flags <= sat_byte(32'(byte_cnt) + 32'd1);
                                        switch   <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (ser_bus_idle) begin
                            state <= ST_INIT;
                        end
                    end
                    default: state <= ST_INIT;
                endcase
            end
        end
    end

    // Saturating statistics counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_ok  <= '0;
            cnt_err <= '0;
        end else if (cnt_clr) begin
            cnt_ok  <= '0;
            cnt_err <= '0;
        end else begin
            if (ok_evt && (cnt_ok != '1)) begin
                cnt_ok <= cnt_ok + 1'b1;
            end
            if (err_evt && (cnt_err != '1)) begin
                cnt_err <= cnt_err + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_ctl.sv
// Scoreboard bench for rx_frame_ctl: stimulus pushes expected writes/switches/errors,
// a negedge monitor pops and compares whenever the DUT strobes.
module tb_rx_frame_ctl;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] filters;
    logic [1:0]  filter_en;
    logic        promisc, user_crc, not_drop, abort, cnt_clr;
    logic        error;
    logic [1:0]  err_code;
    logic [1:0]  match_idx;
    logic        ser_bus_idle;
    logic [7:0]  ser_data;
    logic [15:0] ser_crc_data;
    logic        ser_data_clk;
    logic        ser_force_wait_idle;
    logic [7:0]  wr_byte;
    logic [7:0]  wr_addr;
    logic        wr_clk;
    logic [7:0]  wr_flags;
    logic        switch;
    logic [7:0]  cnt_ok, cnt_err;

    int vectors     = 0;
    int miscompares = 0;
    int force_cnt   = 0;
    logic ignore_wr = 1'b0;
    logic done      = 1'b0;

    logic [15:0] wr_q[$];   // {addr, byte}
    logic [9:0]  sw_q[$];   // {wr_flags, match_idx}
    logic [1:0]  er_q[$];   // err_code

    rx_frame_ctl #(
        .ADDR_W(8), .NUM_FILTERS(2), .MAX_DATA(253), .CNT_W(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .filters(filters), .filter_en(filter_en),
        .promisc(promisc), .user_crc(user_crc), .not_drop(not_drop), .abort(abort),
        .cnt_clr(cnt_clr), .error(error), .err_code(err_code), .match_idx(match_idx),
        .ser_bus_idle(ser_bus_idle), .ser_data(ser_data), .ser_crc_data(ser_crc_data),
        .ser_data_clk(ser_data_clk), .ser_force_wait_idle(ser_force_wait_idle),
        .wr_byte(wr_byte), .wr_addr(wr_addr), .wr_clk(wr_clk), .wr_flags(wr_flags),
        .switch(switch), .cnt_ok(cnt_ok), .cnt_err(cnt_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: compare each DUT strobe against the head of its queue.
    always @(negedge clk) begin
        if (reset_n && !done) begin
            if (wr_clk && !ignore_wr) begin
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", 32'(wr_clk), 32'd0);
                end else begin
                    automatic logic [15:0] e = wr_q.pop_front();
                    check("wr_addr_byte", {16'd0, wr_addr, wr_byte}, {16'd0, e});
                end
            end
            if (switch) begin
                if (sw_q.size() == 0) begin
                    check("switch_unexpected", 32'(switch), 32'd0);
                end else begin
                    automatic logic [9:0] s = sw_q.pop_front();
                    check("switch_flags", 32'(wr_flags), 32'(s[9:2]));
                    check("switch_idx", 32'(match_idx), 32'(s[1:0]));
                end
            end
            if (error) begin
                if (er_q.size() == 0) begin
                    check("error_unexpected", 32'(error), 32'd0);
                end else begin
                    automatic logic [1:0] c = er_q.pop_front();
                    check("error_code", 32'(err_code), 32'(c));
                end
            end
            if (ser_force_wait_idle) force_cnt++;
        end
    end

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // One byte strobe; optional abort/clear alongside, optional bus idle afterwards.
    task automatic put_byte(input logic [7:0] b, input logic [15:0] crc,
                            input logic ab, input logic clr, input logic go_idle);
        ser_data     = b;
        ser_crc_data = crc;
        ser_data_clk = 1'b1;
        abort        = ab;
        cnt_clr      = clr;
        @(posedge clk); #1;
        ser_data_clk = 1'b0;
        abort        = 1'b0;
        cnt_clr      = 1'b0;
        if (go_idle) ser_bus_idle = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input bq_t q, input logic [15:0] crc,
                              input logic ab, input logic clr, input logic idle_end);
        ser_bus_idle = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            automatic logic last = (i == q.size() - 1);
            put_byte(q[i], last ? crc : 16'h0000, last & ab, last & clr, last & idle_end);
        end
    endtask

    task automatic push_wr(input bq_t q, input int n);
        for (int i = 0; i < n; i++) wr_q.push_back({8'(i), q[i]});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t fa, fd, fe, ff, fg;
        fa = '{8'h01, 8'h09, 8'h02, 8'hAA, 8'hBB, 8'h5A, 8'hC3};
        fd = '{8'h01, 8'h09, 8'hFE, 8'h11, 8'h22};
        fe = '{8'h01, 8'hFF, 8'h05, 8'h33};
        ff = '{8'h05, 8'h09, 8'h02, 8'hAA, 8'hBB, 8'h5A, 8'hC3};
        fg = '{8'h05, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'h5A, 8'hC3};

        reset_n = 1'b0; filters = 16'h0905; filter_en = 2'b11;
        promisc = 1'b0; user_crc = 1'b0; not_drop = 1'b1; abort = 1'b0; cnt_clr = 1'b0;
        ser_bus_idle = 1'b1; ser_data = 8'h00; ser_crc_data = 16'h0000; ser_data_clk = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_error",  32'(error),  32'd0);
        check("rst_switch", 32'(switch), 32'd0);
        check("rst_wr_clk", 32'(wr_clk), 32'd0);
        check("rst_flags",  32'(wr_flags), 32'd0);
        check("rst_code",   32'(err_code), 32'd0);
        check("rst_idx",    32'(match_idx), 32'd0);
        check("rst_cnt_ok", 32'(cnt_ok), 32'd0);
        check("rst_cnt_err", 32'(cnt_err), 32'd0);
        check("rst_force",  32'(ser_force_wait_idle), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        gap(3);

        // Good unicast frame to slot 1.
        push_wr(fa, 7); sw_q.push_back({8'h00, 2'd1});
        send_frame(fa, 16'h0000, 1'b0, 1'b0, 1'b1); gap(3);
        check("A_cnt_ok", 32'(cnt_ok), 32'd1);
        check("A_cnt_err", 32'(cnt_err), 32'd0);

        // Bad CRC, stored with flags = 7 bytes.
        push_wr(fa, 7); sw_q.push_back({8'h07, 2'd1}); er_q.push_back(2'd2);
        send_frame(fa, 16'h1234, 1'b0, 1'b0, 1'b1); gap(3);
        check("B_cnt_err", 32'(cnt_err), 32'd1);
        check("B_code", 32'(err_code), 32'd2);

        // Bad CRC, not stored.
        not_drop = 1'b0;
        push_wr(fa, 7); er_q.push_back(2'd2);
        send_frame(fa, 16'h1234, 1'b0, 1'b0, 1'b1); gap(3);
        not_drop = 1'b1;
        check("C_cnt_err", 32'(cnt_err), 32'd2);
        check("C_cnt_ok", 32'(cnt_ok), 32'd1);

        // Oversize len: writes stop after byte 2, trailing bytes ignored until idle.
        push_wr(fd, 3); sw_q.push_back({8'h03, 2'd1}); er_q.push_back(2'd3);
        send_frame(fd, 16'h0000, 1'b0, 1'b0, 1'b1); gap(3);
        check("D_code", 32'(err_code), 32'd3);
        cnt_clr = 1'b1; gap(1); cnt_clr = 1'b0; gap(1);
        check("clr_cnt_ok", 32'(cnt_ok), 32'd0);
        check("clr_cnt_err", 32'(cnt_err), 32'd0);

        // Broadcast frame cut short after 4 bytes.
        push_wr(fe, 4); sw_q.push_back({8'h04, 2'd3}); er_q.push_back(2'd1);
        send_frame(fe, 16'h0000, 1'b0, 1'b0, 1'b1); gap(3);
        check("E_cnt_err", 32'(cnt_err), 32'd1);
        check("E_code", 32'(err_code), 32'd1);

        // Self-echo dropped silently.
        ignore_wr = 1'b1;
        send_frame(ff, 16'h0000, 1'b0, 1'b0, 1'b1); gap(3);
        ignore_wr = 1'b0;
        check("F_cnt_ok", 32'(cnt_ok), 32'd0);
        check("F_cnt_err", 32'(cnt_err), 32'd1);

        // Same source under promisc is accepted.
        promisc = 1'b1;
        push_wr(fg, 7); sw_q.push_back({8'h00, 2'd3});
        send_frame(fg, 16'h0000, 1'b0, 1'b0, 1'b1); gap(3);
        promisc = 1'b0;
        check("G_cnt_ok", 32'(cnt_ok), 32'd1);
        check("G_code_held", 32'(err_code), 32'd1);

        // Abort on the last byte; bus stays busy one cycle so INIT requests resync.
        ignore_wr = 1'b1;
        send_frame(fa, 16'h0000, 1'b1, 1'b0, 1'b0);
        ser_bus_idle = 1'b1;
        gap(3);
        ignore_wr = 1'b0;
        check("H_cnt_ok", 32'(cnt_ok), 32'd1);
        check("H_cnt_err", 32'(cnt_err), 32'd1);
        check("H_force_pulses", 32'(force_cnt), 32'd1);

        // Normal frame after the abort.
        push_wr(fa, 7); sw_q.push_back({8'h00, 2'd1});
        send_frame(fa, 16'h0000, 1'b0, 1'b0, 1'b1); gap(3);
        check("I_cnt_ok", 32'(cnt_ok), 32'd2);

        // Clear in the same cycle as a good-frame increment.
        push_wr(fa, 7); sw_q.push_back({8'h00, 2'd1});
        send_frame(fa, 16'h0000, 1'b0, 1'b1, 1'b1); gap(3);
        check("J_cnt_ok", 32'(cnt_ok), 32'd0);
        check("J_cnt_err", 32'(cnt_err), 32'd0);

        gap(5);
        done = 1'b1;
        check("wr_q_left", 32'(wr_q.size()), 32'd0);
        check("sw_q_left", 32'(sw_q.size()), 32'd0);
        check("er_q_left", 32'(er_q.size()), 32'd0);
        check("force_total", 32'(force_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
